// File: rtl/nf10_tbl_access_arbiter.sv
// ============================================================================
// Module   : nf10_tbl_access_arbiter
// Brief    : Shares one single-port table BRAM between the host register port
//            and the pipelined datapath lookup port, with bounded host wait.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nf10_tbl_access_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_NUM_COLS       = 4,
    parameter int TBL_ADDR_WIDTH     = 2,
    parameter int MEM_RD_LATENCY     = 2,
    parameter int HOST_MAX_WAIT      = 8
) (
    input  logic                                       Bus2IP_Clk,
    input  logic                                       Bus2IP_Resetn,
    input  logic                                       tbl_rd_req,
    input  logic [TBL_ADDR_WIDTH-1:0]                  tbl_rd_addr,
    output logic                                       tbl_rd_ack,
    output logic [TBL_NUM_COLS*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    input  logic                                       tbl_wr_req,
    input  logic [TBL_ADDR_WIDTH-1:0]                  tbl_wr_addr,
    input  logic [TBL_NUM_COLS*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    output logic                                       tbl_wr_ack,
    input  logic                                       dp_lkp_req,
    input  logic [TBL_ADDR_WIDTH-1:0]                  dp_lkp_addr,
    output logic                                       dp_lkp_gnt,
    output logic                                       dp_lkp_vld,
    output logic [TBL_NUM_COLS*C_S_AXI_DATA_WIDTH-1:0] dp_lkp_data,
    output logic                                       mem_en,
    output logic                                       mem_we,
    output logic [TBL_ADDR_WIDTH-1:0]                  mem_addr,
    output logic [TBL_NUM_COLS*C_S_AXI_DATA_WIDTH-1:0] mem_wdata,
    input  logic [TBL_NUM_COLS*C_S_AXI_DATA_WIDTH-1:0] mem_rdata
);

    localparam int W   = TBL_NUM_COLS * C_S_AXI_DATA_WIDTH;
    localparam int L   = MEM_RD_LATENCY;
    localparam int WCW = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(HOST_MAX_WAIT);

    typedef enum logic [1:0] {
        H_IDLE    = 2'd0,
        H_RD_WAIT = 2'd1,
        H_DONE    = 2'd2
    } host_state_t;

    host_state_t    state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [L-1:0]   dp_tag_q, dp_tag_d;
    logic [L-1:0]   host_tag_q, host_tag_d;
    logic           tbl_rd_ack_q, tbl_rd_ack_d;
    logic           tbl_wr_ack_q, tbl_wr_ack_d;
    logic           dp_lkp_vld_q, dp_lkp_vld_d;
    logic [W-1:0]   tbl_rd_data_q, tbl_rd_data_d;
    logic [W-1:0]   dp_lkp_data_q, dp_lkp_data_d;

    logic host_req;
    logic host_issue;
    logic dp_xfer;

    always_comb begin
        host_req   = tbl_rd_req | tbl_wr_req;
        host_issue = (state_q == H_IDLE) && host_req &&
                     (!dp_lkp_req || (wait_cnt_q == WAIT_MAX));
        dp_xfer    = dp_lkp_req && !host_issue;
    end

    // Write wins the address mux when both host requests are raised together.
    always_comb begin
        dp_lkp_gnt = !host_issue;
        mem_en     = host_issue | dp_xfer;
        mem_we     = host_issue & tbl_wr_req;
        mem_wdata  = tbl_wr_data;
        if (host_issue) begin
            mem_addr = tbl_wr_req ? tbl_wr_addr : tbl_rd_addr;
        end else begin
            mem_addr = dp_lkp_addr;
        end
    end

    // Tags travel alongside each read so results are routed to their owner L cycles later.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        dp_tag_d      = dp_tag_q << 1;
        host_tag_d    = host_tag_q << 1;
        dp_tag_d[0]   = dp_xfer;
        host_tag_d[0] = host_issue & !tbl_wr_req;
        tbl_rd_ack_d  = 1'b0;
        tbl_wr_ack_d  = 1'b0;
        tbl_rd_data_d = tbl_rd_data_q;
        dp_lkp_vld_d  = dp_tag_q[L-1];
        dp_lkp_data_d = dp_tag_q[L-1] ? mem_rdata : dp_lkp_data_q;

        if (host_issue) begin
            wait_cnt_d = '0;
        end else if ((state_q == H_IDLE) && host_req && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        case (state_q)
            H_IDLE: begin
                if (host_issue) begin
                    if (tbl_wr_req) begin
                        state_d      = H_DONE;
                        tbl_wr_ack_d = 1'b1;
                    end else begin
                        state_d = H_RD_WAIT;
                    end
                end
            end
            H_RD_WAIT: begin
                if (host_tag_q[L-1]) begin
                    state_d       = H_DONE;
                    tbl_rd_ack_d  = 1'b1;
                    tbl_rd_data_d = mem_rdata;
                end
            end
            H_DONE:  state_d = H_IDLE;
            default: state_d = H_IDLE;
        endcase
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q       <= H_IDLE;
            wait_cnt_q    <= '0;
            dp_tag_q      <= '0;
            host_tag_q    <= '0;
            tbl_rd_ack_q  <= 1'b0;
            tbl_wr_ack_q  <= 1'b0;
            dp_lkp_vld_q  <= 1'b0;
            tbl_rd_data_q <= '0;
            dp_lkp_data_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            dp_tag_q      <= dp_tag_d;
            host_tag_q    <= host_tag_d;
            tbl_rd_ack_q  <= tbl_rd_ack_d;
            tbl_wr_ack_q  <= tbl_wr_ack_d;
            dp_lkp_vld_q  <= dp_lkp_vld_d;
            tbl_rd_data_q <= tbl_rd_data_d;
            dp_lkp_data_q <= dp_lkp_data_d;
        end
    end

    assign tbl_rd_ack  = tbl_rd_ack_q;
    assign tbl_wr_ack  = tbl_wr_ack_q;
    assign tbl_rd_data = tbl_rd_data_q;
    assign dp_lkp_vld  = dp_lkp_vld_q;
    assign dp_lkp_data = dp_lkp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_nf10_tbl_access_arbiter.sv
// ============================================================================
// Module   : tb_nf10_tbl_access_arbiter
// Brief    : Directed self-checking bench for nf10_tbl_access_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nf10_tbl_access_arbiter;

    localparam int W = 128;
    localparam int A = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         rd_req, wr_req, rd_ack, wr_ack, dp_req, dp_gnt, dp_vld, mem_en, mem_we;
    logic [A-1:0] rd_addr, wr_addr, dp_addr, mem_addr;
    logic [W-1:0] wr_data, rd_data, dp_data, mem_wdata, mem_rdata;

    logic         b_wr_req, b_rd_ack, b_wr_ack, b_dp_req, b_dp_gnt, b_dp_vld, b_mem_en, b_mem_we;
    logic [A-1:0] b_mem_addr;
    logic [W-1:0] b_rd_data, b_dp_data, b_mem_wdata;

    nf10_tbl_access_arbiter #(.HOST_MAX_WAIT(8)) u_dut (
        .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n),
        .tbl_rd_req(rd_req), .tbl_rd_addr(rd_addr), .tbl_rd_ack(rd_ack), .tbl_rd_data(rd_data),
        .tbl_wr_req(wr_req), .tbl_wr_addr(wr_addr), .tbl_wr_data(wr_data), .tbl_wr_ack(wr_ack),
        .dp_lkp_req(dp_req), .dp_lkp_addr(dp_addr), .dp_lkp_gnt(dp_gnt),
        .dp_lkp_vld(dp_vld), .dp_lkp_data(dp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    nf10_tbl_access_arbiter #(.HOST_MAX_WAIT(0)) u_dut_strict (
        .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n),
        .tbl_rd_req(1'b0), .tbl_rd_addr(2'd0), .tbl_rd_ack(b_rd_ack), .tbl_rd_data(b_rd_data),
        .tbl_wr_req(b_wr_req), .tbl_wr_addr(2'd1), .tbl_wr_data({W{1'b1}}), .tbl_wr_ack(b_wr_ack),
        .dp_lkp_req(b_dp_req), .dp_lkp_addr(2'd2), .dp_lkp_gnt(b_dp_gnt),
        .dp_lkp_vld(b_dp_vld), .dp_lkp_data(b_dp_data),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata({W{1'b0}})
    );

    // Table BRAM with two cycles of read latency.
    logic [W-1:0] mem [4];
    logic [W-1:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            rd_p0 <= mem[mem_addr];
        end
        rd_p1 <= rd_p0;
    end
    assign mem_rdata = rd_p1;

    logic [W-1:0] exp_row [4];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host access with no datapath traffic; for reads d is the expected row.
    task automatic host_xfer(input bit is_wr, input logic [A-1:0] a, input logic [W-1:0] d,
                             input int exp_lat);
        int lat;
        if (is_wr) begin
            wr_req = 1'b1; wr_addr = a; wr_data = d;
        end else begin
            rd_req = 1'b1; rd_addr = a;
        end
        lat = 0;
        forever begin
            @(negedge clk);
            if (lat == 0) begin
                chk("issue_en", mem_en, 1);
                chk("issue_we", mem_we, is_wr);
                chk("issue_addr", mem_addr, a);
            end
            if ((is_wr ? wr_ack : rd_ack) === 1'b1) break;
            if (lat == 40) break;
            tick();
            lat++;
        end
        chk(is_wr ? "wr_lat" : "rd_lat", lat, exp_lat);
        if (!is_wr) chk("rd_data", rd_data, d);
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", {rd_ack, wr_ack}, 0);
        tick();
    endtask

    initial begin
        rd_req = 0; wr_req = 0; dp_req = 0;
        rd_addr = 0; wr_addr = 0; dp_addr = 0; wr_data = 0;
        b_wr_req = 0; b_dp_req = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_dp_vld", dp_vld, 0);
        chk("rst_dp_data", dp_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 4; r++) begin
            exp_row[r] = {96'h0123_4567_89AB_CDEF_1357_9BDF, 32'hA5A5_0000 + 32'(r)};
            host_xfer(1'b1, 2'(r), exp_row[r], 1);
        end

        // Host write then read of row 2.
        exp_row[2] = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_0002;
        host_xfer(1'b1, 2'd2, exp_row[2], 1);
        host_xfer(1'b0, 2'd2, exp_row[2], 3);

        // Back-to-back datapath lookups.
        for (int k = 0; k < 8; k++) begin
            dp_req  = (k < 4);
            dp_addr = 2'(k % 4);
            @(negedge clk);
            if (k < 4) chk($sformatf("t2_gnt[%0d]", k), dp_gnt, 1);
            chk($sformatf("t2_vld[%0d]", k), dp_vld, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk($sformatf("t2_data[%0d]", k), dp_data, exp_row[k-3]);
            tick();
        end
        dp_req = 0;

        // Host read starved by continuous lookups until the wait limit.
        rd_addr = 2'd1;
        for (int k = 0; k < 16; k++) begin
            int g;
            bit ev;
            dp_req  = (k <= 12);
            dp_addr = 2'(k % 4);
            rd_req  = (k <= 11);
            @(negedge clk);
            if (k <= 12) chk($sformatf("t3_gnt[%0d]", k), dp_gnt, (k != 8));
            if (k == 8) begin
                chk("t3_host_addr", mem_addr, 1);
                chk("t3_host_we", mem_we, 0);
            end
            g  = k - 3;
            ev = (g >= 0 && g <= 12 && g != 8);
            chk($sformatf("t3_vld[%0d]", k), dp_vld, ev);
            if (ev) chk($sformatf("t3_data[%0d]", k), dp_data, exp_row[g % 4]);
            chk($sformatf("t3_rd_ack[%0d]", k), rd_ack, (k == 11));
            if (k == 11) chk("t3_rd_data", rd_data, exp_row[1]);
            tick();
        end
        dp_req = 0;
        rd_req = 0;

        // Strict host priority on the second instance.
        b_wr_req = 1; b_dp_req = 1;
        @(negedge clk);
        chk("t4_en", b_mem_en, 1);
        chk("t4_we", b_mem_we, 1);
        chk("t4_gnt0", b_dp_gnt, 0);
        tick();
        @(negedge clk);
        chk("t4_ack", b_wr_ack, 1);
        chk("t4_gnt1", b_dp_gnt, 1);
        chk("t4_dp_en", b_mem_en, 1);
        chk("t4_dp_we", b_mem_we, 0);
        chk("t4_dp_addr", b_mem_addr, 2);
        tick();
        b_wr_req = 0; b_dp_req = 0;

        // Reset with reads in flight.
        rd_req = 1; rd_addr = 2'd3;
        @(negedge clk);
        chk("t5_host_issue", mem_en & ~dp_gnt, 1);
        tick();
        dp_req = 1; dp_addr = 2'd0;
        @(negedge clk);
        chk("t5_gnt_a", dp_gnt, 1);
        tick();
        dp_addr = 2'd1;
        @(negedge clk);
        chk("t5_gnt_b", dp_gnt, 1);
        #1;
        rst_n = 0; rd_req = 0; dp_req = 0;
        @(negedge clk);
        chk("t5_rst_rd_ack", rd_ack, 0);
        chk("t5_rst_wr_ack", wr_ack, 0);
        chk("t5_rst_rd_data", rd_data, 0);
        chk("t5_rst_dp_vld", dp_vld, 0);
        chk("t5_rst_dp_data", dp_data, 0);
        chk("t5_rst_mem_en", mem_en, 0);
        tick();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t5_post_vld[%0d]", k), dp_vld, 0);
            chk($sformatf("t5_post_ack[%0d]", k), rd_ack, 0);
            tick();
        end
        host_xfer(1'b0, 2'd3, exp_row[3], 3);

        // Simultaneous read and write to one row: write first.
        exp_row[0] = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
        wr_req = 1; rd_req = 1; wr_addr = 2'd0; rd_addr = 2'd0; wr_data = exp_row[0];
        @(negedge clk);
        chk("t6_we", mem_we, 1);
        tick();
        @(negedge clk);
        chk("t6_wr_ack", wr_ack, 1);
        chk("t6_rd_ack_early", rd_ack, 0);
        tick();
        wr_req = 0;
        for (int k = 2; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) chk("t6_rd_issue", {mem_en, mem_we}, 2'b10);
            chk($sformatf("t6_rd_ack[%0d]", k), rd_ack, (k == 5));
            if (k == 5) chk("t6_rd_data", rd_data, exp_row[0]);
            tick();
        end
        rd_req = 0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
